prbs_link_tester: RTL and testbench
===================================

Name: prbs_link_tester

Overview:
- Parametrised successor to the modulator top's fixed valid-divider plus single PRBS source.
- Combines three functions:
  - a programmable symbol-rate strobe generator;
  - an N_CH-channel PRBS generator with selectable polynomial;
  - a per-channel self-synchronising PRBS checker with lock detection and error/bit counters.
- Sits between the modulator datapath (FIR) and the board LEDs/debug registers, for loopback BER measurement.

Parameters:
- NB_COUNT, 3: width of the rate divider and of i_rate.
- N_CH, 2: number of independent PRBS channels (1..64).
- NB_ERR, 16: width of each error counter and of the bit counter.
- LOCK_N, 16: consecutive correct predictions needed to lock.
- LOSS_N, 4: consecutive mismatches while locked that force loss of lock.

Ports:
- clock, input, 1: single system clock, rising edge.
- i_reset, input, 1: synchronous, active-high reset.
- i_enable, input, 1: generator enable.
- i_rate, input, NB_COUNT: strobe period minus 1.
- i_mode, input, 1: 0 = PRBS7 (x^7+x^6+1); 1 = PRBS9 (x^9+x^5+1).
- i_check_en, input, 1: checker enable.
- i_clear, input, 1: one-cycle pulse that zeroes all counters.
- i_rx_valid, input, 1: received-bit strobe.
- i_rx_data, input, N_CH: received bits, one per channel.
- o_valid, output, 1: one-cycle symbol strobe.
- o_data, output, N_CH: generated PRBS bits.
- o_lock, output, N_CH: per-channel checker lock.
- o_err_count, output, N_CH*NB_ERR: per-channel error counts, channel k at bits [k*NB_ERR +: NB_ERR].
- o_bit_count, output, NB_ERR: count of checked rx bits.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - count=0, o_valid=0, o_data=0, o_lock=0, all counters 0, checkers in HUNT;
  - LFSR k loaded with seed all-ones minus k, using 9 bits in PRBS9 mode and the low 7 bits in PRBS7 mode.
- Divider:
  - While i_enable=1: count increments; when count==i_rate, count returns to 0 and o_valid is 1 on the next cycle.
  - i_rate=0 gives o_valid high every cycle.
  - While i_enable=0: count holds, o_valid=0.
- Generator:
  - On the edge that sets o_valid, o_data[k] takes the LFSR k MSB (bit 6 for PRBS7, bit 8 for PRBS9).
  - At the same edge the LFSR shifts left with feedback into bit 0: bit6^bit5 for PRBS7, bit8^bit4 for PRBS9.
  - o_data holds between strobes.
  - Sequence period: 127 for PRBS7, 511 for PRBS9.
- Mode change: i_mode is registered. A change detected on any cycle causes, on the next edge:
  - all LFSRs reseed;
  - all checkers return to HUNT with history and match counters cleared, o_lock=0;
  - counters are not cleared.
- Checker, per channel, advancing only on cycles with i_rx_valid=1 and i_check_en=1:
  - State: 9-bit history, fill counter, match counter, mismatch counter.
  - Prediction = tap XOR of the history, using the same taps as the generator.
  - HUNT:
    - The received bit shifts into the history.
    - Once the history holds ORDER bits (7 or 9), a correct prediction increments the match counter and a mismatch zeroes it.
    - When the match counter reaches LOCK_N: go to LOCKED, o_lock=1 on the next cycle.
  - LOCKED:
    - The history shifts in the prediction, not the received bit, so one flipped bit gives exactly one error.
    - A mismatch increments the error count (saturating at all-ones) and the mismatch counter.
    - A match zeroes the mismatch counter.
    - When the mismatch counter reaches LOSS_N: go to HUNT, o_lock=0, history cleared.
- Bit counter: increments on every checker-advancing cycle, saturating.
- i_clear:
  - Zeroes the error and bit counters at the next edge; lock state is unaffected.
  - A count event in the same cycle is discarded (clear wins).
- i_check_en=0 freezes all checker state; i_rx_valid is ignored.
- Reset dominates all other inputs.

Test Plan:
1. Rate: NB_COUNT=3, i_rate=7, i_enable raised at cycle 0 after reset → o_valid high at cycles 8, 16, 24…; with i_rate=0 → o_valid high every cycle from cycle 1.
2. PRBS7: ch0 loopback (o_data→i_rx_data, o_valid→i_rx_valid) → first 7 bits of ch0 are 1, period 127, 64 ones per period. o_lock[0] rises within 7+16 strobes. After 1000 bits: o_err_count[ch0]=0, o_bit_count=1000.
3. Single error: while locked, invert one ch1 bit → ch1 error count +1 exactly, o_lock[1] stays 1, ch0 count unchanged.
4. Loss: while locked, invert the entire ch0 stream → error count +4, o_lock[0] falls after the 4th inverted bit and never relocks; the inverted PRBS always mispredicts.
5. Mode switch: PRBS7 locked, toggle i_mode to 1 → o_lock all 0 the cycle after detection. PRBS9 first 9 bits of ch0 are 1, period 511, relock within 9+16 strobes.
6. Saturation/clear: NB_ERR=4, 20 injected errors → count holds at 15. i_clear asserted with a simultaneous error → count=0 and o_lock unchanged.

Source files
------------

// File: rtl/prbs_link_tester.sv
// Loopback BER tester: programmable symbol strobe, N_CH PRBS7/PRBS9 generators,
// and per-channel self-synchronising checkers with lock, error and bit counters.
module prbs_link_tester #(
  parameter int unsigned NB_COUNT = 3,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned NB_ERR   = 16,
  parameter int unsigned LOCK_N   = 16,
  parameter int unsigned LOSS_N   = 4
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [NB_COUNT-1:0]      i_rate,
  input  logic                     i_mode,
  input  logic                     i_check_en,
  input  logic                     i_clear,
  input  logic                     i_rx_valid,
  input  logic [N_CH-1:0]          i_rx_data,
  output logic                     o_valid,
  output logic [N_CH-1:0]          o_data,
  output logic [N_CH-1:0]          o_lock,
  output logic [N_CH*NB_ERR-1:0]   o_err_count,
  output logic [NB_ERR-1:0]        o_bit_count
);

  localparam int unsigned NB_LFSR  = 9;
  localparam int unsigned NB_FILL  = 4;
  localparam int unsigned NB_MATCH = $clog2(LOCK_N + 1);
  localparam int unsigned NB_MISS  = $clog2(LOSS_N + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  logic                              mode_q;
  logic                              mode_chg;
  logic                              strobe;
  logic                              adv;
  logic [NB_FILL-1:0]                order;

  logic [NB_COUNT-1:0]               count_q, count_d;
  logic                              valid_q, valid_d;
  logic [N_CH-1:0]                   data_q, data_d;
  logic [N_CH-1:0][NB_LFSR-1:0]      lfsr_q, lfsr_d;

  chk_state_e                        state_q [N_CH];
  chk_state_e                        state_d [N_CH];
  logic [N_CH-1:0][NB_LFSR-1:0]      hist_q, hist_d;
  logic [N_CH-1:0][NB_FILL-1:0]      fill_q, fill_d;
  logic [N_CH-1:0][NB_MATCH-1:0]     match_q, match_d;
  logic [N_CH-1:0][NB_MISS-1:0]      miss_q, miss_d;
  logic [N_CH-1:0][NB_ERR-1:0]       err_q, err_d;
  logic [NB_ERR-1:0]                 bits_q, bits_d;
  logic [N_CH-1:0]                   pred;
  logic [N_CH-1:0]                   hit;
  logic [N_CH-1:0]                   err_inc;

  // Channel k seeds with all-ones minus k; PRBS7 only looks at the low 7 bits.
  function automatic logic [NB_LFSR-1:0] seed_of(input int unsigned k);
    return 9'h1FF - 9'(k);
  endfunction

  assign mode_chg = (i_mode != mode_q);
  assign adv      = i_rx_valid && i_check_en;
  assign order    = mode_q ? 4'd9 : 4'd7;

  // Rate divider and PRBS generators
  always_comb begin
    strobe  = i_enable && (count_q == i_rate);
    count_d = count_q;
    valid_d = strobe;
    data_d  = data_q;
    lfsr_d  = lfsr_q;
    if (i_enable) begin
      count_d = strobe ? '0 : NB_COUNT'(count_q + 1'b1);
    end
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (strobe) begin
        data_d[k] = mode_q ? lfsr_q[k][8] : lfsr_q[k][6];
      end
      if (mode_chg) begin
        lfsr_d[k] = seed_of(k);
      end else if (strobe) begin
        lfsr_d[k] = {lfsr_q[k][7:0],
                     mode_q ? (lfsr_q[k][8] ^ lfsr_q[k][4])
                            : (lfsr_q[k][6] ^ lfsr_q[k][5])};
      end
    end
  end

  // Checkers: while locked the history runs on its own predictions
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_inc = '0;
    pred    = '0;
    hit     = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      pred[k] = mode_q ? (hist_q[k][8] ^ hist_q[k][4]) : (hist_q[k][6] ^ hist_q[k][5]);
      hit[k]  = (i_rx_data[k] == pred[k]);
      if (mode_chg) begin
        state_d[k] = HUNT;
        hist_d[k]  = '0;
        fill_d[k]  = '0;
        match_d[k] = '0;
        miss_d[k]  = '0;
      end else if (adv) begin
        case (state_q[k])
          HUNT: begin
            hist_d[k] = {hist_q[k][7:0], i_rx_data[k]};
            if (fill_q[k] != order) begin
              fill_d[k] = NB_FILL'(fill_q[k] + 1'b1);
            end else if (!hit[k]) begin
              match_d[k] = '0;
            end else if (match_q[k] == NB_MATCH'(LOCK_N - 1)) begin
              state_d[k] = LOCKED;
              match_d[k] = '0;
              miss_d[k]  = '0;
            end else begin
              match_d[k] = NB_MATCH'(match_q[k] + 1'b1);
            end
          end
          LOCKED: begin
            hist_d[k] = {hist_q[k][7:0], pred[k]};
            if (hit[k]) begin
              miss_d[k] = '0;
            end else begin
              err_inc[k] = 1'b1;
              if (miss_q[k] == NB_MISS'(LOSS_N - 1)) begin
                state_d[k] = HUNT;
                hist_d[k]  = '0;
                fill_d[k]  = '0;
                match_d[k] = '0;
                miss_d[k]  = '0;
              end else begin
                miss_d[k] = NB_MISS'(miss_q[k] + 1'b1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturating error/bit counters; a clear beats a same-cycle count
  always_comb begin
    err_d  = err_q;
    bits_d = bits_q;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (i_clear) begin
        err_d[k] = '0;
      end else if (err_inc[k] && (err_q[k] != '1)) begin
        err_d[k] = NB_ERR'(err_q[k] + 1'b1);
      end
    end
    if (i_clear) begin
      bits_d = '0;
    end else if (adv && (bits_q != '1)) begin
      bits_d = NB_ERR'(bits_q + 1'b1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      mode_q  <= i_mode;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      bits_q  <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        lfsr_q[k]  <= seed_of(k);
        state_q[k] <= HUNT;
      end
    end else begin
      mode_q  <= i_mode;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      bits_q  <= bits_d;
    end
  end

  always_comb begin
    o_lock = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      o_lock[k] = (state_q[k] == LOCKED);
    end
  end

  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_err_count = err_q;
  assign o_bit_count = bits_q;

endmodule

// File: tb/tb_prbs_link_tester.sv
// Directed/randomised loopback bench for prbs_link_tester against a
// recurrence-based PRBS model; a second 4-bit-counter instance covers saturation.
module tb_prbs_link_tester;

  logic        clock;
  logic        i_reset, i_enable, i_mode, i_check_en, i_clear;
  logic [2:0]  i_rate;
  logic [1:0]  inj;
  logic        o_valid;
  logic [1:0]  o_data, o_lock, rx_data;
  logic [31:0] o_err_count;
  logic [15:0] o_bit_count;

  logic        s_enable, s_check_en, s_clear, s_inj;
  logic        s_valid;
  logic [0:0]  s_data, s_lock, s_rx_data;
  logic [3:0]  s_err, s_bits;

  int total, bad;
  int sidx;
  bit cur_mode;
  bit m7 [2][127];
  bit m9 [2][511];

  assign rx_data   = o_data ^ inj;
  assign s_rx_data = s_data ^ s_inj;

  prbs_link_tester dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_rate(i_rate),
    .i_mode(i_mode), .i_check_en(i_check_en), .i_clear(i_clear),
    .i_rx_valid(o_valid), .i_rx_data(rx_data),
    .o_valid(o_valid), .o_data(o_data), .o_lock(o_lock),
    .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  prbs_link_tester #(.N_CH(1), .NB_ERR(4)) dut_s (
    .clock(clock), .i_reset(i_reset), .i_enable(s_enable), .i_rate(3'd0),
    .i_mode(1'b0), .i_check_en(s_check_en), .i_clear(s_clear),
    .i_rx_valid(s_valid), .i_rx_data(s_rx_data),
    .o_valid(s_valid), .o_data(s_data), .o_lock(s_lock),
    .o_err_count(s_err), .o_bit_count(s_bits)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // s[n] = s[n-ORD] ^ s[n-ORD+off], first ORD symbols are the seed MSB-first
  task automatic build_model();
    logic [6:0] v7;
    logic [8:0] v9;
    for (int ch = 0; ch < 2; ch++) begin
      v7 = 7'h7F - 7'(ch);
      v9 = 9'h1FF - 9'(ch);
      for (int n = 0; n < 127; n++)
        m7[ch][n] = (n < 7) ? v7[6-n] : (m7[ch][n-7] ^ m7[ch][n-6]);
      for (int n = 0; n < 511; n++)
        m9[ch][n] = (n < 9) ? v9[8-n] : (m9[ch][n-9] ^ m9[ch][n-5]);
    end
  endtask

  function automatic logic [1:0] exp_data(input bit m, input int n);
    if (m) return {m9[1][n % 511], m9[0][n % 511]};
    return {m7[1][n % 127], m7[0][n % 127]};
  endfunction

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("stream_data", o_data, exp_data(cur_mode, sidx));
      sidx++;
    end
  endtask

  initial begin
    int r, ones, k, e_exp, relock;
    int rates [3];
    total = 0; bad = 0; sidx = 0; cur_mode = 0;
    i_reset = 1; i_enable = 0; i_rate = 0; i_mode = 0; i_check_en = 0; i_clear = 0; inj = 0;
    s_enable = 0; s_check_en = 0; s_clear = 0; s_inj = 0;
    build_model();
    tick(); tick();

    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_lock", o_lock, 0);
    chk("rst_err", o_err_count, 0);
    chk("rst_bits", o_bit_count, 0);

    // Divider: strobe in cycle c iff c is a multiple of rate+1
    rates[0] = 7; rates[1] = $urandom_range(1, 6); rates[2] = 0;
    for (int j = 0; j < 3; j++) begin
      r = rates[j];
      i_reset = 1; tick(); i_reset = 0;
      i_enable = 1; i_rate = 3'(r);
      for (int c = 1; c <= 24; c++) begin
        tick();
        chk("div_valid", o_valid, ((c % (r + 1)) == 0) ? 1 : 0);
      end
    end
    i_enable = 0; tick(); tick();
    chk("div_hold_valid", o_valid, 0);
    chk("freeze_bits", o_bit_count, 0);

    // PRBS7 loopback from reset
    i_reset = 1; tick(); i_reset = 0;
    i_enable = 1; i_rate = 0; i_check_en = 1; ones = 0;
    for (int n = 1; n <= 1001; n++) begin
      tick();
      chk("p7_data", o_data, exp_data(0, n - 1));
      if (n <= 127) ones += int'(o_data[0]);
      if (n == 23) chk("p7_lock_early", o_lock, 0);
      if (n == 24) chk("p7_lock", o_lock, 3);
    end
    sidx = 1001;
    chk("p7_ones", ones, 64);
    chk("p7_bits", o_bit_count, 1000);
    chk("p7_err", o_err_count, 0);

    // Isolated errors on ch1
    inj = 2'b10; adv(1); inj = 0; adv(5);
    chk("single_err1", o_err_count[31:16], 1);
    chk("single_err0", o_err_count[15:0], 0);
    chk("single_lock", o_lock, 3);
    k = $urandom_range(2, 5);
    for (int i = 0; i < k; i++) begin
      inj = 2'b10; adv(1); inj = 0;
      adv($urandom_range(5, 20));
    end
    chk("multi_err1", o_err_count[31:16], 1 + k);
    chk("multi_lock", o_lock, 3);

    // Inverted ch0 stream: 4 errors, then unlock with no relock
    inj = 2'b01; adv(3);
    chk("loss_hold", o_lock[0], 1);
    adv(1);
    chk("loss_drop", o_lock[0], 0);
    chk("loss_err0", o_err_count[15:0], 4);
    relock = 0;
    for (int i = 0; i < 300; i++) begin
      adv(1);
      if (o_lock[0]) relock = 1;
    end
    chk("loss_no_relock", relock, 0);
    chk("loss_err0_final", o_err_count[15:0], 4);
    chk("loss_ch1_lock", o_lock[1], 1);
    inj = 0; adv(40);
    chk("relock7", o_lock, 3);

    // Mode switch to PRBS9
    i_enable = 0; tick();
    chk("dis_valid", o_valid, 0);
    i_mode = 1; tick();
    chk("mode_unlock", o_lock, 0);
    chk("mode_keep_err0", o_err_count[15:0], 4);
    chk("mode_keep_err1", o_err_count[31:16], 1 + k);
    i_enable = 1; ones = 0;
    for (int n = 1; n <= 700; n++) begin
      tick();
      chk("p9_data", o_data, exp_data(1, n - 1));
      if (n <= 511) ones += int'(o_data[0]);
      if (n == 25) chk("p9_lock_early", o_lock, 0);
      if (n == 26) chk("p9_lock", o_lock, 3);
    end
    chk("p9_ones", ones, 256);

    // Reset dominates
    i_clear = 0; i_reset = 1; tick();
    chk("rst2_valid", o_valid, 0);
    chk("rst2_data", o_data, 0);
    chk("rst2_lock", o_lock, 0);
    chk("rst2_err", o_err_count, 0);
    chk("rst2_bits", o_bit_count, 0);
    i_reset = 0; i_enable = 0;

    // 4-bit counters: saturation and clear precedence
    s_enable = 1; s_check_en = 1;
    repeat (30) tick();
    chk("s_lock", s_lock, 1);
    chk("s_bits_sat", s_bits, 15);
    e_exp = 0;
    for (int i = 0; i < 20; i++) begin
      s_inj = 1; tick(); s_inj = 0;
      e_exp = (e_exp + 1 > 15) ? 15 : e_exp + 1;
      repeat ($urandom_range(5, 8)) tick();
    end
    chk("s_err_sat", s_err, e_exp);
    chk("s_lock_sat", s_lock, 1);
    s_inj = 1; s_clear = 1; tick(); s_inj = 0; s_clear = 0;
    chk("s_clear_err", s_err, 0);
    chk("s_clear_bits", s_bits, 0);
    chk("s_clear_lock", s_lock, 1);
    repeat (5) tick();
    s_inj = 1; tick(); s_inj = 0; tick();
    chk("s_after_clear", s_err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
